// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Tracks the destination register of the instructions in flight in the EX,
//   MEM and WB stages and produces the ID-stage stall and the operand
//   forwarding selects. A load in EX that feeds an ID read stalls for one
//   cycle (load-use). A MULTU/DIVU leaving ID keeps HI/LO busy for MULDIV_LAT
//   cycles. Any ID read of HI/LO (index 33) stalls while HI/LO is busy, and
//   so does any further MULTU/DIVU.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous, active-low reset
//   id_valid      ID stage holds a real instruction
//   id_rr1/rr2    ID read indices (0 = $zero, 33 = HI/LO)
//   id_wr         ID write index, 0 = no write
//   id_is_load    ID instruction is a load
//   id_is_muldiv  ID instruction is MULTU/DIVU
//   flush         squash the ID instruction (taken branch/jump)
//   stall         hold PC and IF/ID, insert a bubble into EX
//   fwd_a/fwd_b   operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
//   hilo_busy     HI/LO counter nonzero
//   ex_wr         tracked EX destination, 0 for a bubble
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int MULDIV_LAT = 4,
    parameter int IDX_W      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [IDX_W-1:0] id_rr1,
    input  logic [IDX_W-1:0] id_rr2,
    input  logic [IDX_W-1:0] id_wr,
    input  logic             id_is_load,
    input  logic             id_is_muldiv,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             hilo_busy,
    output logic [IDX_W-1:0] ex_wr
);

    localparam logic [IDX_W-1:0] HILO_IDX = IDX_W'(33);
    localparam logic [3:0]       LAT      = 4'(MULDIV_LAT);

    // Slot registers: _p0 = EX, _p1 = MEM, _p2 = WB
    logic             v_p0, v_p1, v_p2;
    logic [IDX_W-1:0] wr_p0, wr_p1, wr_p2;
    logic             ld_p0, ld_p1, ld_p2;
    logic [3:0]       hilo_cnt;

    logic ex_m1, mem_m1, wb_m1;
    logic ex_m2, mem_m2, wb_m2;
    logic load_use, hilo_haz, accept;

    // $zero and HI/LO are never forwarded: $zero is constant and HI/LO
    // hazards are handled entirely by the busy counter.
    function automatic logic slot_match(input logic v,
                                        input logic [IDX_W-1:0] wr,
                                        input logic [IDX_W-1:0] r);
        return v && (wr == r) && (r != '0) && (r != HILO_IDX);
    endfunction

    // A load in EX has no result yet, so it falls through to MEM/WB; the
    // load-use stall guarantees the value is picked up from MEM next cycle.
    function automatic logic [1:0] fwd_sel(input logic ex_m, input logic ex_ld,
                                           input logic mem_m, input logic wb_m);
        if (ex_m && !ex_ld) return 2'd1;
        else if (mem_m)     return 2'd2;
        else if (wb_m)      return 2'd3;
        else                return 2'd0;
    endfunction

    assign ex_m1  = slot_match(v_p0, wr_p0, id_rr1);
    assign mem_m1 = slot_match(v_p1, wr_p1, id_rr1);
    assign wb_m1  = slot_match(v_p2, wr_p2, id_rr1);
    assign ex_m2  = slot_match(v_p0, wr_p0, id_rr2);
    assign mem_m2 = slot_match(v_p1, wr_p1, id_rr2);
    assign wb_m2  = slot_match(v_p2, wr_p2, id_rr2);

    assign fwd_a = fwd_sel(ex_m1, ld_p0, mem_m1, wb_m1);
    assign fwd_b = fwd_sel(ex_m2, ld_p0, mem_m2, wb_m2);

    assign load_use  = v_p0 & ld_p0 & (ex_m1 | ex_m2);
    assign hilo_busy = (hilo_cnt != 4'd0);
    assign hilo_haz  = hilo_busy & ((id_rr1 == HILO_IDX) | (id_rr2 == HILO_IDX) | id_is_muldiv);

    // Flush wins over stall: a squashed instruction never holds the front end.
    assign stall  = id_valid & ~flush & (load_use | hilo_haz);
    assign accept = id_valid & ~flush & ~stall;

    assign ex_wr = v_p0 ? wr_p0 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_p0     <= 1'b0;
            wr_p0    <= '0;
            ld_p0    <= 1'b0;
            v_p1     <= 1'b0;
            wr_p1    <= '0;
            ld_p1    <= 1'b0;
            v_p2     <= 1'b0;
            wr_p2    <= '0;
            ld_p2    <= 1'b0;
            hilo_cnt <= 4'd0;
        end else begin
            // ---- ID -> EX ----
            if (accept) begin
                v_p0  <= 1'b1;
                wr_p0 <= id_wr;
                ld_p0 <= id_is_load;
            end else begin
                v_p0  <= 1'b0;
                wr_p0 <= '0;
                ld_p0 <= 1'b0;
            end
            // ---- EX -> MEM ----
            v_p1  <= v_p0;
            wr_p1 <= wr_p0;
            ld_p1 <= ld_p0;
            // ---- MEM -> WB ----
            v_p2  <= v_p1;
            wr_p2 <= wr_p1;
            ld_p2 <= ld_p1;

            // A MULTU/DIVU is never accepted while busy, so load and
            // decrement cannot collide.
            if (accept && id_is_muldiv) begin
                hilo_cnt <= LAT;
            end else if (hilo_cnt != 4'd0) begin
                hilo_cnt <= hilo_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int LAT = 4;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [5:0] id_rr1, id_rr2, id_wr;
    logic       id_is_load, id_is_muldiv, flush;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;
    logic       hilo_busy;
    logic [5:0] ex_wr;

    hazard_scoreboard #(.MULDIV_LAT(LAT), .IDX_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rr1(id_rr1), .id_rr2(id_rr2), .id_wr(id_wr),
        .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv), .flush(flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .hilo_busy(hilo_busy), .ex_wr(ex_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st; int fa; int fb; int hb; int ew;
    } exp_t;
    exp_t expq[$];

    // Reference model: a list of accepted instructions stamped with the
    // cycle they left ID; their pipeline stage is simply their age.
    typedef struct {
        int wr; bit ld; int iss;
    } rec_t;
    rec_t recs[$];
    int   cyc = 0;
    int   busy_until = -100;

    int total = 0;
    int bad   = 0;

    function automatic bit hit(int iss, int r, bit need_alu);
        foreach (recs[i])
            if (recs[i].iss == iss && recs[i].wr == r && (!need_alu || !recs[i].ld))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_fwd(int r);
        if (r == 0 || r == 33) return 0;
        if (hit(cyc - 1, r, 1'b1)) return 1;
        if (hit(cyc - 2, r, 1'b0)) return 2;
        if (hit(cyc - 3, r, 1'b0)) return 3;
        return 0;
    endfunction

    task automatic step(input bit rst, input bit v, input int r1, input int r2,
                        input int w, input bit ld, input bit md, input bit fl);
        exp_t e;
        bit   lu, hb, hh, st, acc;
        int   ew;
        @(negedge clk);
        rst_n        = ~rst;
        id_valid     = v;
        id_rr1       = 6'(r1);
        id_rr2       = 6'(r2);
        id_wr        = 6'(w);
        id_is_load   = ld;
        id_is_muldiv = md;
        flush        = fl;
        if (rst) begin
            recs.delete();
            busy_until = -100;
            e = '{st: 0, fa: 0, fb: 0, hb: 0, ew: 0};
        end else begin
            while (recs.size() > 0 && recs[0].iss < cyc - 3) void'(recs.pop_front());
            lu = 1'b0;
            ew = 0;
            foreach (recs[i])
                if (recs[i].iss == cyc - 1) begin
                    ew = recs[i].wr;
                    if (recs[i].ld && ((r1 == recs[i].wr && r1 != 0 && r1 != 33) ||
                                       (r2 == recs[i].wr && r2 != 0 && r2 != 33)))
                        lu = 1'b1;
                end
            hb  = (cyc <= busy_until);
            hh  = hb && (r1 == 33 || r2 == 33 || md);
            st  = v && !fl && (lu || hh);
            acc = v && !fl && !st;
            e   = '{st: int'(st), fa: model_fwd(r1), fb: model_fwd(r2), hb: int'(hb), ew: ew};
            if (acc) begin
                recs.push_back('{wr: w, ld: ld, iss: cyc});
                if (md) busy_until = cyc + LAT;
            end
        end
        expq.push_back(e);
        cyc++;
    endtask

    task automatic cmp(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, req);
        end
    endtask

    // Monitor: checks the outputs presented in each cycle well after the
    // driver has settled them and before the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                cmp("stall",     int'(stall),     e.st);
                cmp("fwd_a",     int'(fwd_a),     e.fa);
                cmp("fwd_b",     int'(fwd_b),     e.fb);
                cmp("hilo_busy", int'(hilo_busy), e.hb);
                cmp("ex_wr",     int'(ex_wr),     e.ew);
            end
        end
    end

    function automatic int rand_idx();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return 33;
            2:       return 31;
            default: return int'($urandom_range(1, 6));
        endcase
    endfunction

    initial begin
        int wait_cnt;
        rst_n = 1'b0; id_valid = 1'b0; id_rr1 = '0; id_rr2 = '0; id_wr = '0;
        id_is_load = 1'b0; id_is_muldiv = 1'b0; flush = 1'b0;

        // reset with live-looking inputs
        step(1, 1, 5, 0, 0, 0, 0, 0);
        step(1, 1, 5, 5, 7, 1, 0, 0);
        // ADD wr=8 then read it through EX, MEM, WB, regfile
        step(0, 1, 1, 2, 8, 0, 0, 0);
        repeat (4) step(0, 1, 8, 0, 0, 0, 0, 0);
        // load-use
        step(0, 1, 1, 2, 9, 1, 0, 0);
        step(0, 1, 0, 9, 0, 0, 0, 0);
        step(0, 1, 0, 9, 0, 0, 0, 0);
        // double hit: EX wins over MEM, then $zero never forwarded
        step(0, 1, 1, 2, 4, 0, 0, 0);
        step(0, 1, 1, 2, 4, 0, 0, 0);
        step(0, 1, 4, 4, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // MULTU, back-to-back DIVU, then MFLO
        step(0, 1, 1, 2, 33, 0, 1, 0);
        step(0, 1, 3, 5, 33, 0, 1, 0);
        repeat (5) step(0, 1, 33, 0, 6, 0, 0, 0);
        step(0, 1, 33, 0, 6, 0, 0, 0);
        repeat (4) step(0, 1, 33, 0, 6, 0, 0, 0);
        // flush over stall, flushed MULTU never sets busy
        step(0, 1, 1, 2, 3, 1, 0, 0);
        step(0, 1, 3, 0, 0, 0, 0, 1);
        step(0, 1, 1, 2, 33, 0, 1, 1);
        step(0, 1, 33, 0, 7, 0, 0, 0);
        // reset in the middle of a busy window
        step(0, 1, 1, 2, 33, 0, 1, 0);
        step(0, 1, 33, 0, 7, 0, 0, 0);
        step(0, 1, 33, 0, 7, 0, 0, 0);
        step(1, 1, 33, 0, 7, 0, 0, 0);
        step(0, 1, 33, 0, 7, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            bit r, v, ld, md, fl;
            int w;
            r  = ($urandom_range(0, 99) < 2);
            v  = ($urandom_range(0, 9) < 8);
            md = ($urandom_range(0, 9) == 0);
            ld = !md && ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            w  = md ? 33 : (($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6)));
            step(r, v, rand_idx(), rand_idx(), w, ld, md, fl);
        end

        wait_cnt = 0;
        while (expq.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #3;
        if (expq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d expected=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
